fired_tag_fifo: RTL and testbench
=================================

Name: fired_tag_fifo

Overview:
- Buffers tags of neurons that fired in the current timestep, between the neuron update stage (producer) and the synaptic processing unit (consumer).
- Show-ahead FIFO: head tag is always visible on src_tag_out; the consumer samples it, then pulses req_deq to pop.
- Flags empty/full/overflow and keeps an occupancy count for the timestep controller.

Parameters:
- numneurons, 2, number of neurons in the network.
- tagbits, 1, width of a neuron tag; must satisfy 2^tagbits >= numneurons.
- depthbits, 1, log2 of FIFO depth; depth = 2^depthbits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- asyn_reset  input  1  reset; synchronous, active-high, sampled on the rising edge of clk; port name kept for compatibility with sibling blocks.
- wr_en  input  1  push request from the neuron update stage.
- wr_tag  input  tagbits  tag of the fired neuron to push.
- req_deq  input  1  pop request from the synaptic processing unit.
- clear_step  input  1  timestep boundary pulse; used by the optional feature only.
- src_tag_out  output  tagbits  head-of-queue tag; 0 when empty.
- fifo_empty  output  1  queue holds no entries.
- fifo_full  output  1  queue holds 2^depthbits entries.
- count  output  depthbits+1  current occupancy.
- overflow  output  1  sticky flag: a push was dropped.

Behaviour:
- Storage: 2^depthbits x tagbits register array, read pointer rd_ptr, write pointer wr_ptr (depthbits wide, natural wrap), occupancy counter cnt.
- Reset (asyn_reset high at a clock edge) overrides all other inputs on that edge:
  - rd_ptr, wr_ptr, cnt, overflow = 0.
  - fifo_empty = 1, fifo_full = 0, src_tag_out = 0, count = 0.
  - Array contents need not be cleared.
  - Reset mid-operation discards all queued tags.
- Outputs:
  - src_tag_out = mem[rd_ptr] when cnt != 0, else 0. Combinational from registers, so there is no read latency.
  - fifo_empty = (cnt == 0), fifo_full = (cnt == 2^depthbits), count = cnt. All are driven from registers.
- Pop:
  - req_deq high at an edge with cnt != 0: rd_ptr+1, cnt-1.
  - req_deq while empty: ignored; no state change.
  - The consumer samples src_tag_out at the edge where it raises req_deq, so the popped entry is the one it already captured. The consumer must leave at least one cycle between pops; req_deq may stay high for only one cycle per pop.
- Push:
  - wr_en high and (cnt < depth, or a pop succeeds on the same edge): mem[wr_ptr] <= wr_tag, wr_ptr+1, cnt+1.
  - Push latency: the tag is visible on src_tag_out the cycle after the edge if the queue was empty.
- Simultaneous events:
  - Push + pop when not empty and not full: both happen; cnt unchanged.
  - Push + pop when full: both accepted; cnt stays full, and no overflow is raised.
  - Push + pop when empty: the pop is ignored and the push is accepted; cnt becomes 1.
- Overflow: wr_en when full with no successful pop: the tag is dropped, overflow <= 1. overflow stays set until reset; clear_step does not clear it.
- Wrap-around: pointers wrap modulo 2^depthbits with no bubble.

Optional Feature:
- Macro FIRED_FIFO_DEDUP_EN.
- Defined:
  - A numneurons-bit enqueued bitmap, reset to 0.
  - A push whose wr_tag bit is already set is silently discarded. It does not touch the pointers or cnt and does not set overflow.
  - An accepted push sets the bitmap bit for its tag.
  - clear_step high at an edge clears the bitmap. A push on that same edge is evaluated against the cleared bitmap, and its bit is set afterwards.
  - Pops do not clear bits, so each neuron is queued at most once per timestep.
- Undefined:
  - No bitmap; duplicate tags are queued.
  - clear_step is ignored.

Test Plan:
1. Reset with numneurons=4, tagbits=2, depthbits=2: after the edge, fifo_empty=1, count=0, src_tag_out=0, overflow=0.
2. Push 3, then 1 on consecutive cycles, then pulse req_deq:
   - src_tag_out=3 one cycle after the first push.
   - count=2 after the second push.
   - After the pop: src_tag_out=1, count=1.
3. Fill to 4 entries (0,1,2,3), so fifo_full=1. Then:
   - Push 2 alone: dropped, overflow=1, count=4, head=0.
   - Push 2 together with req_deq: head becomes 1, count=4, overflow still 1.
4. Push + pop on the same edge when empty: the pop is ignored and count=1.
5. Wrap-around: 6 alternating push/pop pairs with tags 0..5 mod 4. Each popped value equals the pushed value, and fifo_empty=1 at the end.
6. With FIRED_FIFO_DEDUP_EN:
   - Push 2 twice: count=1.
   - Pulse clear_step, then push 2: count=2.
   - Without the macro, the first two pushes give count=2.

Source files
------------

// File: rtl/fired_tag_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : fired_tag_fifo_if
// Brief    : Producer/consumer bundle for the fired-neuron tag FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface fired_tag_fifo_if #(
  parameter int TAGBITS   = 1,
  parameter int DEPTHBITS = 1
);
  logic                 wr_en;
  logic [TAGBITS-1:0]   wr_tag;
  logic                 req_deq;
  logic                 clear_step;
  logic [TAGBITS-1:0]   src_tag_out;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [DEPTHBITS:0]   count;
  logic                 overflow;

  modport master (
    output wr_en, wr_tag, req_deq, clear_step,
    input  src_tag_out, fifo_empty, fifo_full, count, overflow
  );

  modport slave (
    input  wr_en, wr_tag, req_deq, clear_step,
    output src_tag_out, fifo_empty, fifo_full, count, overflow
  );
endinterface
`default_nettype wire

// File: rtl/fired_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fired_tag_fifo
// Brief    : Show-ahead FIFO of fired-neuron tags between neuron update and
//            synaptic processing. Optional macro FIRED_FIFO_DEDUP_EN drops
//            repeat tags within a timestep.
// Revision : 1.0 - initial release
// ============================================================================
module fired_tag_fifo #(
  parameter int NUMNEURONS = 2,
  parameter int TAGBITS    = 1,
  parameter int DEPTHBITS  = 1
) (
  input  wire logic        clk,
  input  wire logic        asyn_reset,
  fired_tag_fifo_if.slave  bus
);

  localparam int                 c_DEPTH = 2 ** DEPTHBITS;
  localparam logic [DEPTHBITS:0] c_FULL  = (DEPTHBITS+1)'(c_DEPTH);

  logic [TAGBITS-1:0]   mem_q [c_DEPTH];
  logic [DEPTHBITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTHBITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTHBITS:0]   cnt_q, cnt_d;
  logic                 overflow_q, overflow_d;

  logic w_not_empty;
  logic w_full;
  logic w_pop;
  logic w_dup;
  logic w_push_req;
  logic w_push;

  assign w_not_empty = (cnt_q != '0);
  assign w_full      = (cnt_q == c_FULL);
  assign w_pop       = bus.req_deq & w_not_empty;
  assign w_push_req  = bus.wr_en & ~w_dup;
  // A pop on the same edge frees the slot, so a full queue still accepts.
  assign w_push      = w_push_req & (~w_full | w_pop);

`ifdef FIRED_FIFO_DEDUP_EN
  logic [NUMNEURONS-1:0] bitmap_q, bitmap_d;
  logic [NUMNEURONS-1:0] w_tag_onehot;
  logic [NUMNEURONS-1:0] w_bitmap_base;

  always_comb begin
    w_tag_onehot = '0;
    for (int i = 0; i < NUMNEURONS; i++) begin
      w_tag_onehot[i] = (bus.wr_tag == TAGBITS'(i));
    end
  end

  // A push coinciding with clear_step sees the already-cleared bitmap.
  assign w_bitmap_base = bus.clear_step ? '0 : bitmap_q;
  assign w_dup         = |(w_bitmap_base & w_tag_onehot);
  assign bitmap_d      = w_push ? (w_bitmap_base | w_tag_onehot) : w_bitmap_base;

  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      bitmap_q <= '0;
    end else begin
      bitmap_q <= bitmap_d;
    end
  end
`else
  logic w_unused_clear_step;
  assign w_unused_clear_step = bus.clear_step;
  assign w_dup               = 1'b0;
`endif

  always_comb begin
    rd_ptr_d   = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d   = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    overflow_d = overflow_q | (w_push_req & w_full & ~w_pop);
    cnt_d      = cnt_q;
    case ({w_push, w_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (!asyn_reset && w_push) begin
      mem_q[wr_ptr_q] <= bus.wr_tag;
    end
  end

  assign bus.src_tag_out = w_not_empty ? mem_q[rd_ptr_q] : '0;
  assign bus.fifo_empty  = ~w_not_empty;
  assign bus.fifo_full   = w_full;
  assign bus.count       = cnt_q;
  assign bus.overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fired_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_fired_tag_fifo
// Brief    : Directed and random checks of fired_tag_fifo against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fired_tag_fifo;

  localparam int NUMN  = 4;
  localparam int TAGB  = 2;
  localparam int DEPB  = 2;
  localparam int DEPTH = 4;

  logic clk;
  logic asyn_reset;

  fired_tag_fifo_if #(.TAGBITS(TAGB), .DEPTHBITS(DEPB)) bus ();

  fired_tag_fifo #(
    .NUMNEURONS (NUMN),
    .TAGBITS    (TAGB),
    .DEPTHBITS  (DEPB)
  ) u_dut (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  int m_q[$];
  bit m_ovf;
  bit m_bm[NUMN];

  task automatic chk(input string name, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_ovf = 1'b0;
    foreach (m_bm[i]) m_bm[i] = 1'b0;
  endtask

  task automatic model_edge(input bit we, input int tg, input bit dq, input bit clr);
    bit dup;
    dup = 1'b0;
`ifdef FIRED_FIFO_DEDUP_EN
    if (clr) foreach (m_bm[i]) m_bm[i] = 1'b0;
    dup = we && m_bm[tg];
`endif
    if (dq && m_q.size() > 0) void'(m_q.pop_front());
    if (we && !dup) begin
      if (m_q.size() < DEPTH) begin
        m_q.push_back(tg);
        m_bm[tg] = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    int exp_head;
    exp_head = (m_q.size() > 0) ? m_q[0] : 0;
    chk("head",     int'(bus.src_tag_out), exp_head);
    chk("count",    int'(bus.count),       m_q.size());
    chk("empty",    int'(bus.fifo_empty),  (m_q.size() == 0) ? 1 : 0);
    chk("full",     int'(bus.fifo_full),   (m_q.size() == DEPTH) ? 1 : 0);
    chk("overflow", int'(bus.overflow),    int'(m_ovf));
  endtask

  task automatic step(input bit we, input int tg, input bit dq, input bit clr);
    asyn_reset     = 1'b0;
    bus.wr_en      = we;
    bus.wr_tag     = TAGB'(tg);
    bus.req_deq    = dq;
    bus.clear_step = clr;
    model_edge(we, tg, dq, clr);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Other inputs are randomised to show reset takes priority over them.
  task automatic do_reset();
    asyn_reset     = 1'b1;
    bus.wr_en      = 1'($urandom_range(0, 1));
    bus.wr_tag     = TAGB'($urandom_range(0, 3));
    bus.req_deq    = 1'($urandom_range(0, 1));
    bus.clear_step = 1'($urandom_range(0, 1));
    model_clear();
    @(posedge clk);
    #1;
    asyn_reset = 1'b0;
    check_all();
  endtask

  initial begin
    bit prev_dq;
    n_cmp = 0;
    n_bad = 0;
    asyn_reset     = 1'b1;
    bus.wr_en      = 1'b0;
    bus.wr_tag     = '0;
    bus.req_deq    = 1'b0;
    bus.clear_step = 1'b0;
    model_clear();

    // Reset state
    do_reset();
    chk("rst_empty", int'(bus.fifo_empty), 1);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_head", int'(bus.src_tag_out), 0);
    chk("rst_ovf", int'(bus.overflow), 0);

    // Push 3, push 1, pop
    step(1, 3, 0, 0);
    chk("t2_head3", int'(bus.src_tag_out), 3);
    step(1, 1, 0, 0);
    chk("t2_cnt2", int'(bus.count), 2);
    step(0, 0, 1, 0);
    chk("t2_head1", int'(bus.src_tag_out), 1);
    chk("t2_cnt1", int'(bus.count), 1);
    step(0, 0, 0, 0);

    // Fill, overflow, push+pop when full
    do_reset();
    for (int i = 0; i < 4; i++) step(1, i, 0, 0);
    chk("t3_full", int'(bus.fifo_full), 1);
    step(1, 2, 0, 1);
    chk("t3_ovf", int'(bus.overflow), 1);
    chk("t3_cnt", int'(bus.count), 4);
    chk("t3_head0", int'(bus.src_tag_out), 0);
    step(1, 2, 1, 1);
    chk("t3_head1", int'(bus.src_tag_out), 1);
    chk("t3_cnt_pp", int'(bus.count), 4);
    chk("t3_ovf_sticky", int'(bus.overflow), 1);
    step(0, 0, 0, 1);
    chk("t3_ovf_clr", int'(bus.overflow), 1);

    // Push+pop while empty
    do_reset();
    step(1, 2, 1, 0);
    chk("t4_cnt", int'(bus.count), 1);
    chk("t4_head", int'(bus.src_tag_out), 2);

    // Wrap-around
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, i % 4, 0, 1);
      chk("t5_head", int'(bus.src_tag_out), i % 4);
      step(0, 0, 1, 0);
    end
    chk("t5_empty", int'(bus.fifo_empty), 1);

    // Duplicate tags
    do_reset();
    step(1, 2, 0, 0);
    step(1, 2, 0, 0);
`ifdef FIRED_FIFO_DEDUP_EN
    chk("t6_dup_cnt", int'(bus.count), 1);
    step(0, 0, 0, 1);
    step(1, 2, 0, 0);
    chk("t6_after_clr", int'(bus.count), 2);
    chk("t6_no_ovf", int'(bus.overflow), 0);
`else
    chk("t6_dup_cnt", int'(bus.count), 2);
`endif

    // Random traffic; pops never on consecutive cycles
    do_reset();
    prev_dq = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
        prev_dq = 1'b0;
      end else begin
        bit we, dq, clr;
        int tg;
        we  = ($urandom_range(0, 99) < 55);
        tg  = int'($urandom_range(0, 3));
        dq  = !prev_dq && ($urandom_range(0, 99) < 60);
        clr = ($urandom_range(0, 99) < 10);
        step(we, tg, dq, clr);
        prev_dq = dq;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
